// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/sub datapath.
package adder_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;

    // Operation select carried on the 'sub' pin.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Bits handled by each pipeline stage. A bad stage count falls back to
    // the full width so elaboration reaches the parameter check instead of
    // dividing by zero.
    function automatic int slice_width(input int width, input int stages);
        return (stages < 1) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple adder built from full-adder cells. Also exposes
// the carry into the top bit so the last stage can form signed overflow.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    logic [SW:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SW; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[SW];
    assign c_msb = c[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES slices; operands are skewed forward and finished sum slices are
// carried along so every bit of one operation leaves in the same cycle.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    op_e op;
    assign op = op_e'(sub);

    // Stage registers: skewed operands, accumulated low sum bits, carry.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic              ovf_q;
    logic [STAGES-1:0] vld_pipe;

    // Per-stage combinational view: inputs to the slice and next register value.
    logic [WIDTH-1:0]  st_a  [STAGES];
    logic [WIDTH-1:0]  st_b  [STAGES];
    logic [WIDTH-1:0]  st_s  [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [SLICE-1:0]  sl_s  [STAGES];
    logic              st_cm [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_co;

    // Valid chain with the incoming beat at the bottom; the top bit is the output.
    logic [STAGES:0]   vld_chain;
    logic              en;

    assign vld_chain = {vld_pipe, in_valid};
    assign out_valid = vld_chain[STAGES];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtraction is A + ~B + 1; cin is ignored for sub.
            assign st_a[k] = a;
            assign st_b[k] = b ^ {WIDTH{op == OP_SUB}};
            assign st_c[k] = (op == OP_SUB) ? 1'b1 : cin;
            assign st_s[k] = '0;
        end else begin : g_next
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_c[k] = c_q[k-1];
            assign st_s[k] = s_q[k-1];
        end

        adder_slice #(.SW(SLICE)) u_slice (
            .a     (st_a[k][k*SLICE +: SLICE]),
            .b     (st_b[k][k*SLICE +: SLICE]),
            .ci    (st_c[k]),
            .s     (sl_s[k]),
            .co    (st_co[k]),
            .c_msb (st_cm[k])
        );

        // Bits at and above this slice are still zero in st_s, so OR merges.
        assign nxt_s[k] = st_s[k] | (WIDTH'(sl_s[k]) << (k * SLICE));
    end

    // Advance every stage together under the single global enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            vld_pipe <= vld_chain[STAGES-1:0];
            c_q      <= st_co;
            ovf_q    <= st_cm[STAGES-1] ^ st_co[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                s_q[k] <= nxt_s[k];
            end
        end
    end

    assign sum  = s_q[STAGES-1];
    assign cout = c_q[STAGES-1];
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases, random
// streams under random backpressure, stall hold and mid-flight reset.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk, rst_n;
    logic         in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   done;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: signed/unsigned integer arithmetic on wide values.
    function automatic res_t model(input logic [W-1:0] ma, mb, input logic mc, ms);
        res_t   r;
        longint ua, ub, sa, sb, ru, rs;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            ru     = ua - ub;
            rs     = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            ru     = ua + ub + longint'(mc);
            rs     = sa + sb + longint'(mc);
            r.cout = (ru >= (longint'(1) << W));
        end
        r.sum = ru[W-1:0];
        r.ovf = (rs > SMAX) || (rs < SMIN);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model side: record every accepted beat, forget everything on reset.
    always @(posedge clk)
        if (rst_n && in_valid && in_ready)
            exp_q.push_back(model(a, b, cin, sub));

    always @(negedge rst_n) exp_q.delete();

    // Every emitted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_sum", sum, e.sum);
                chk("out_cout", cout, e.cout);
                chk("out_ovf", ovf, e.ovf);
                n_out++;
            end
        end
    end

    // Called and returns at posedge+1; holds the beat until it is accepted.
    task automatic send(input logic [W-1:0] ta, tb, input logic tc, ts);
        bit acc;
        acc = 1'b0;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Single operation on an empty pipe: check values against constants and latency.
    task automatic run_one(input logic [W-1:0] ta, tb, input logic tc, ts,
                           input logic [W-1:0] es, input logic ec, eo, input string tag);
        int lat;
        bit found;
        lat = 0;
        found = 1'b0;
        out_ready = 1'b1;
        send(ta, tb, tc, ts);
        in_valid = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                lat = i;
                chk({tag, "_sum"}, sum, es);
                chk({tag, "_cout"}, cout, ec);
                chk({tag, "_ovf"}, ovf, eo);
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_latency"}, lat, S);
    endtask

    initial begin
        int n0, cnt;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; done = 1'b0;

        // Reset held with random stimulus on every input.
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom); a = $urandom; b = $urandom;
            cin = 1'($urandom); sub = 1'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_cout", cout, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_in_ready", in_ready, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        idle(2);

        // Directed corners.
        run_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "carry_chain");
        run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_add");
        run_one(32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, "cin_only");
        run_one(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        run_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        run_one(32'h10, 32'h3, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0, "sub_cin_ignored");

        // Backpressure: 8 back-to-back ops, 3-cycle stall on the first result.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send($urandom, $urandom, 1'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    seen = out_valid;
                end
                if (!seen) chk("bp_first_result_timeout", 0, 1);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    if (exp_q.size() > 0) chk("bp_sum_held", sum, exp_q[0].sum);
                    else chk("bp_queue_empty", 0, 1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        chk("bp_count", n_out - n0, 8);

        // Random stream with random gaps and random backpressure.
        n0 = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send($urandom, $urandom, 1'($urandom), 1'($urandom));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rand_drain");
        chk("rand_count", n_out - n0, 40);

        // Mid-flight reset: three ops in flight, first one sitting at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_sum", sum, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rstmid_no_stale", cnt, 0);
        @(posedge clk);
        #1;
        run_one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
